sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares the single-port synchronous data/instruction SRAM between the instruction-fetch requester and the EXE-stage load/store requester. It grants one request per cycle and generates byte-lane write strobes and replicated write data for sub-word stores. It traps misaligned accesses and routes the one-cycle-latency read data back to the requester that issued the read. It sits between the IF/EXE stages and the SRAM macro, and replaces the direct EXE-to-SRAM connection.

## Interface
Parameters:
- MAX_DATA_STREAK, 4, consecutive data grants allowed while an instruction request waits (1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request; held with inst_addr until inst_gnt
- inst_addr  in  32  fetch address (word aligned; bits [1:0] ignored)
- inst_cancel  in  1  flush: drops the fetch response due this cycle
- inst_gnt  out  1  fetch request accepted this cycle
- inst_rvalid  out  1  inst_rdata valid
- inst_rdata  out  32  fetched word
- data_req  in  1  load/store request; held with data_* until data_gnt
- data_we  in  1  1 = store, 0 = load
- data_size  in  2  0 byte, 1 half, 2 word, 3 reserved (treated as word)
- data_addr  in  32  byte address
- data_wdata  in  32  store data, right-justified
- data_gnt  out  1  data request accepted this cycle
- data_ale  out  1  misaligned data access, pulses with data_gnt
- data_rvalid  out  1  data_rdata valid (loads only)
- data_rdata  out  32  raw loaded word; lane extraction and sign extension stay in EXE
- sram_en  out  1  SRAM access enable
- sram_we  out  4  byte write enables
- sram_addr  out  32  {addr[31:2], 2'b00}
- sram_wdata  out  32  lane-replicated store data
- sram_rdata  in  32  SRAM read data, valid 1 cycle after a read enable

## Operation
- Arbitration, combinational, evaluated each cycle:
  - data_req wins by default.
  - inst_req wins when data_req is low, or when streak == MAX_DATA_STREAK.
  - At most one gnt per cycle; no grant when neither request is asserted.
- streak counter (4 bits), updated at posedge:
  - Cleared on reset, on inst_gnt, or when inst_req is low.
  - Incremented on data_gnt while inst_req is high.
  - Saturates at MAX_DATA_STREAK.
- Alignment check:
  - half with addr[0]=1 is misaligned.
  - word/reserved with addr[1:0]≠0 is misaligned.
  - A misaligned data request is still granted (data_gnt=1, data_ale=1) and consumes the cycle, but sram_en=0, sram_we=0, and no rvalid follows.
- Store lanes:
  - byte: sram_we = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - half: sram_we = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - word: sram_we = 4'b1111; wdata = wdata.
- Loads and fetches: sram_we = 0, sram_en = 1.
- Idle cycle: sram_en=0, sram_we=0. sram_addr and sram_wdata are don't-care, but driven from data_* to avoid X.
- Response tracking, registered and updated at posedge:
  - rsp_inst <= inst_gnt.
  - rsp_data <= data_gnt & ~data_we & ~data_ale.
- inst_rvalid = rsp_inst & ~inst_cancel.
- data_rvalid = rsp_data.
- Both rdata outputs drive sram_rdata directly; they are valid only while their rvalid is high.
- inst_cancel in any other cycle has no effect. It never suppresses a grant.

## Timing
- Grant is combinational in the request cycle. The SRAM access occurs on the same edge.
- Read latency: rvalid is asserted exactly 1 cycle after the gnt cycle.
- Back-to-back grants allowed every cycle.
  - Sequence data-load then inst-fetch: data_rvalid in cycle N+1 and inst_rvalid in cycle N+2.
  - rvalid of two consecutive grants never overlaps.
- Stores: no response. Write takes effect at the gnt edge.
- Reset: all registered state is 0 (streak, rsp_inst, rsp_data). All outputs read 0 during and after reset until a request arrives.
- Reset asserted mid-read (cycle after gnt): the pending rvalid is dropped.
- Requests asserted during reset are not granted.
- Requester obligation: req, addr, and data stay stable until gnt. The arbiter assumes this and does not check it.

## Test plan
- Reset, then no requests for 3 cycles -> all outputs 0, sram_en 0.
- Single fetch, inst_addr=0x1c000004, SRAM word 0xDEADBEEF -> inst_gnt cycle 0 with sram_addr=0x1c000004; inst_rvalid=1 and inst_rdata=0xDEADBEEF in cycle 1.
- Simultaneous inst_req and data_req held high, MAX_DATA_STREAK=4 -> grant pattern D,D,D,D,I repeating. Data cannot be starved when inst is idle.
- Stores:
  - byte at addr 0x...3, wdata=0x000000A5 -> sram_we=1000, sram_wdata=0xA5A5A5A5.
  - half at 0x...2, wdata 0x1234 -> sram_we=1100, sram_wdata=0x12341234.
- Misaligned accesses:
  - half load at 0x...1 -> data_gnt=1, data_ale=1, sram_en=0, no data_rvalid next cycle.
  - word store at 0x...2 -> same response, sram_we=0.
- Fetch granted, inst_cancel=1 the next cycle -> inst_rvalid stays 0.
- Reset asserted in the cycle after a load grant -> data_rvalid stays 0.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Requester/SRAM bundle for the shared SRAM port; slave side is the arbiter.
// Pure wiring: no latency, no backpressure beyond the req/gnt handshake.
interface sram_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_cancel;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_we;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_ale;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport master (
    output inst_req, inst_addr, inst_cancel,
    output data_req, data_we, data_size, data_addr, data_wdata,
    output sram_rdata,
    input  inst_gnt, inst_rvalid, inst_rdata,
    input  data_gnt, data_ale, data_rvalid, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata
  );

  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    input  data_req, data_we, data_size, data_addr, data_wdata,
    input  sram_rdata,
    output inst_gnt, inst_rvalid, inst_rdata,
    output data_gnt, data_ale, data_rvalid, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port between fetch and load/store; grant is combinational, read data 1 cycle later.
// Backpressure: losing requester holds req until gnt; data wins except after MAX_DATA_STREAK grants.
module sram_port_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  sram_port_arbiter_if.slave  bus_io
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);
  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HALF  = 2'd1;

  logic [3:0]  streak_q, streak_d;
  logic        rsp_inst_q, rsp_inst_d;
  logic        rsp_data_q, rsp_data_d;

  logic        inst_win;
  logic        data_win;
  logic        misaligned;
  logic        data_ok;
  logic        inst_rvalid;
  logic        data_rvalid;
  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus_io.inst_addr[1:0];

  // Fetch jumps the queue only once data has held the port for a full streak.
  always_comb begin
    inst_win = 1'b0;
    data_win = 1'b0;
    if (!reset_i) begin
      if (bus_io.inst_req && (!bus_io.data_req || streak_q == STREAK_MAX)) begin
        inst_win = 1'b1;
      end else if (bus_io.data_req) begin
        data_win = 1'b1;
      end
    end
  end

  always_comb begin
    misaligned = 1'b0;
    case (bus_io.data_size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = bus_io.data_addr[0];
      default:   misaligned = |bus_io.data_addr[1:0];
    endcase
  end

  always_comb begin
    lane_we    = 4'b1111;
    lane_wdata = bus_io.data_wdata;
    case (bus_io.data_size)
      SIZE_BYTE: begin
        lane_we    = 4'b0001 << bus_io.data_addr[1:0];
        lane_wdata = {4{bus_io.data_wdata[7:0]}};
      end
      SIZE_HALF: begin
        lane_we    = bus_io.data_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{bus_io.data_wdata[15:0]}};
      end
      default: begin
        lane_we    = 4'b1111;
        lane_wdata = bus_io.data_wdata;
      end
    endcase
  end

  assign data_ok = data_win & ~misaligned;

  always_comb begin
    streak_d = streak_q;
    if (inst_win || !bus_io.inst_req) begin
      streak_d = 4'd0;
    end else if (data_win && streak_q != STREAK_MAX) begin
      streak_d = streak_q + 4'd1;
    end
  end

  assign rsp_inst_d = inst_win;
  assign rsp_data_d = data_ok & ~bus_io.data_we;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      streak_q   <= 4'd0;
      rsp_inst_q <= 1'b0;
      rsp_data_q <= 1'b0;
    end else begin
      streak_q   <= streak_d;
      rsp_inst_q <= rsp_inst_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Reset also masks a response already in flight so nothing leaks out of it.
  assign inst_rvalid = rsp_inst_q & ~bus_io.inst_cancel & ~reset_i;
  assign data_rvalid = rsp_data_q & ~reset_i;

  assign bus_io.inst_gnt    = inst_win;
  assign bus_io.inst_rvalid = inst_rvalid;
  assign bus_io.inst_rdata  = inst_rvalid ? bus_io.sram_rdata : 32'd0;

  assign bus_io.data_gnt    = data_win;
  assign bus_io.data_ale    = data_win & misaligned;
  assign bus_io.data_rvalid = data_rvalid;
  assign bus_io.data_rdata  = data_rvalid ? bus_io.sram_rdata : 32'd0;

  assign bus_io.sram_en    = inst_win | data_ok;
  assign bus_io.sram_we    = (data_ok && bus_io.data_we) ? lane_we : 4'b0000;
  assign bus_io.sram_addr  = reset_i  ? 32'd0 :
                             inst_win ? {bus_io.inst_addr[31:2], 2'b00} :
                                        {bus_io.data_addr[31:2], 2'b00};
  assign bus_io.sram_wdata = reset_i ? 32'd0 : lane_wdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboarded bench for sram_port_arbiter with a behavioural 1-cycle SRAM.
module tb_sram_port_arbiter;
  localparam int MAX_STREAK = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_port_arbiter_if bus ();

  sram_port_arbiter #(.MAX_DATA_STREAK(MAX_STREAK)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus_io  (bus)
  );

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] rd_q;

  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_we == 4'b0000) begin
        rd_q <= mem[bus.sram_addr[9:2]];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (bus.sram_we[b]) mem[bus.sram_addr[9:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
        end
      end
    end
  end
  assign bus.sram_rdata = rd_q;

  int n_checks = 0;
  int n_errors = 0;
  bit exp_inst_now = 0, exp_inst_next = 0;
  bit exp_data_now = 0, exp_data_next = 0;
  logic [31:0] exp_inst_q [$];
  logic [31:0] exp_data_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.inst_req    = 1'b0;
    bus.inst_addr   = 32'd0;
    bus.inst_cancel = 1'b0;
    bus.data_req    = 1'b0;
    bus.data_we     = 1'b0;
    bus.data_size   = 2'd0;
    bus.data_addr   = 32'd0;
    bus.data_wdata  = 32'd0;
  endtask

  // Negedge: response checks against what was scheduled by the previous cycle.
  task automatic tick_neg();
    @(negedge clk);
    check("inst_rvalid", 32'(bus.inst_rvalid), 32'(exp_inst_now));
    check("data_rvalid", 32'(bus.data_rvalid), 32'(exp_data_now));
    if (exp_inst_now && exp_inst_q.size() > 0) check("inst_rdata", bus.inst_rdata, exp_inst_q.pop_front());
    if (exp_data_now && exp_data_q.size() > 0) check("data_rdata", bus.data_rdata, exp_data_q.pop_front());
  endtask

  task automatic tick_pos();
    @(posedge clk);
    #1;
    exp_inst_now  = exp_inst_next;
    exp_data_now  = exp_data_next;
    exp_inst_next = 1'b0;
    exp_data_next = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".inst_gnt"},   32'(bus.inst_gnt), 32'd0);
    check({tag, ".data_gnt"},   32'(bus.data_gnt), 32'd0);
    check({tag, ".data_ale"},   32'(bus.data_ale), 32'd0);
    check({tag, ".sram_en"},    32'(bus.sram_en), 32'd0);
    check({tag, ".sram_we"},    32'(bus.sram_we), 32'd0);
    check({tag, ".sram_addr"},  bus.sram_addr, 32'd0);
    check({tag, ".sram_wdata"}, bus.sram_wdata, 32'd0);
    check({tag, ".inst_rdata"}, bus.inst_rdata, 32'd0);
    check({tag, ".data_rdata"}, bus.data_rdata, 32'd0);
  endtask

  // One data request cycle; leaves the request asserted for the caller to change.
  task automatic do_data(input string tag, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] exp_we, input logic [31:0] exp_wdata, input bit exp_ale);
    int idx;
    int lane;
    idx  = int'(addr[9:2]);
    lane = int'(addr[1:0]);
    bus.inst_req   = 1'b0;
    bus.data_req   = 1'b1;
    bus.data_we    = we;
    bus.data_size  = size;
    bus.data_addr  = addr;
    bus.data_wdata = wdata;
    tick_neg();
    check({tag, ".data_gnt"},  32'(bus.data_gnt), 32'd1);
    check({tag, ".inst_gnt"},  32'(bus.inst_gnt), 32'd0);
    check({tag, ".data_ale"},  32'(bus.data_ale), 32'(exp_ale));
    check({tag, ".sram_en"},   32'(bus.sram_en), 32'(!exp_ale));
    check({tag, ".sram_we"},   32'(bus.sram_we), 32'(exp_we));
    check({tag, ".sram_addr"}, bus.sram_addr, {addr[31:2], 2'b00});
    if (we && !exp_ale) begin
      check({tag, ".sram_wdata"}, bus.sram_wdata, exp_wdata);
      case (size)
        2'd0:    ref_mem[idx][8*lane +: 8]        = wdata[7:0];
        2'd1:    ref_mem[idx][16*(lane/2) +: 16]  = wdata[15:0];
        default: ref_mem[idx]                     = wdata;
      endcase
    end
    if (!we && !exp_ale) begin
      exp_data_q.push_back(ref_mem[idx]);
      exp_data_next = 1'b1;
    end
    tick_pos();
  endtask

  initial begin
    logic [31:0] w;
    rd_q = 32'd0;
    for (int i = 0; i < 256; i++) begin
      w = {8'h5A, 8'(i), 8'(~i), 8'(i * 3)};
      mem[i] = w;
      ref_mem[i] = w;
    end
    mem[1] = 32'hDEADBEEF;
    ref_mem[1] = 32'hDEADBEEF;

    // Requests during reset must not be granted.
    reset = 1'b1;
    drive_idle();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1c000004;
    bus.data_req  = 1'b1;
    repeat (2) begin
      tick_neg();
      check_quiet("rst");
      tick_pos();
    end

    reset = 1'b0;
    drive_idle();
    repeat (3) begin
      tick_neg();
      check_quiet("idle");
      tick_pos();
    end

    // Single fetch.
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1c000004;
    tick_neg();
    check("fetch.inst_gnt",  32'(bus.inst_gnt), 32'd1);
    check("fetch.data_gnt",  32'(bus.data_gnt), 32'd0);
    check("fetch.sram_en",   32'(bus.sram_en), 32'd1);
    check("fetch.sram_we",   32'(bus.sram_we), 32'd0);
    check("fetch.sram_addr", bus.sram_addr, 32'h1c000004);
    exp_inst_q.push_back(32'hDEADBEEF);
    exp_inst_next = 1'b1;
    tick_pos();
    drive_idle();
    tick_neg();
    tick_pos();

    // Both requesting: D,D,D,D,I repeating.
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h0000_0008;
    bus.data_req  = 1'b1;
    bus.data_we   = 1'b0;
    bus.data_size = 2'd2;
    bus.data_addr = 32'h0000_0010;
    for (int c = 0; c < 10; c++) begin
      tick_neg();
      if (c % (MAX_STREAK + 1) == MAX_STREAK) begin
        check($sformatf("streak%0d.inst_gnt", c), 32'(bus.inst_gnt), 32'd1);
        check($sformatf("streak%0d.data_gnt", c), 32'(bus.data_gnt), 32'd0);
        exp_inst_q.push_back(ref_mem[2]);
        exp_inst_next = 1'b1;
      end else begin
        check($sformatf("streak%0d.inst_gnt", c), 32'(bus.inst_gnt), 32'd0);
        check($sformatf("streak%0d.data_gnt", c), 32'(bus.data_gnt), 32'd1);
        exp_data_q.push_back(ref_mem[4]);
        exp_data_next = 1'b1;
      end
      tick_pos();
    end
    bus.inst_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick_neg();
      check($sformatf("dataonly%0d.data_gnt", c), 32'(bus.data_gnt), 32'd1);
      exp_data_q.push_back(ref_mem[4]);
      exp_data_next = 1'b1;
      tick_pos();
    end
    drive_idle();
    tick_neg();
    tick_pos();

    // Sub-word stores, then read back merged words.
    do_data("st_b3", 1'b1, 2'd0, 32'h0000_0023, 32'h0000_00A5, 4'b1000, 32'hA5A5A5A5, 1'b0);
    do_data("st_h2", 1'b1, 2'd1, 32'h0000_0022, 32'h0000_1234, 4'b1100, 32'h12341234, 1'b0);
    do_data("st_b1", 1'b1, 2'd0, 32'h0000_0021, 32'h0000_003C, 4'b0010, 32'h3C3C3C3C, 1'b0);
    do_data("st_h0", 1'b1, 2'd1, 32'h0000_0024, 32'hFFFF_BEEF, 4'b0011, 32'hBEEFBEEF, 1'b0);
    do_data("st_w",  1'b1, 2'd2, 32'h0000_0028, 32'hCAFE_F00D, 4'b1111, 32'hCAFEF00D, 1'b0);
    do_data("ld_20", 1'b0, 2'd2, 32'h0000_0020, 32'd0, 4'b0000, 32'd0, 1'b0);
    do_data("ld_24", 1'b0, 2'd2, 32'h0000_0024, 32'd0, 4'b0000, 32'd0, 1'b0);
    do_data("ld_28", 1'b0, 2'd0, 32'h0000_002B, 32'd0, 4'b0000, 32'd0, 1'b0);

    // Misaligned accesses: granted, flagged, no SRAM access, no response.
    do_data("ml_h1", 1'b0, 2'd1, 32'h0000_0041, 32'd0, 4'b0000, 32'd0, 1'b1);
    do_data("ms_w2", 1'b1, 2'd2, 32'h0000_0042, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b1);
    do_data("ml_r3", 1'b0, 2'd3, 32'h0000_0043, 32'd0, 4'b0000, 32'd0, 1'b1);
    do_data("ml_w1", 1'b0, 2'd2, 32'h0000_0051, 32'd0, 4'b0000, 32'd0, 1'b1);
    do_data("ld_r",  1'b0, 2'd3, 32'h0000_002C, 32'd0, 4'b0000, 32'd0, 1'b0);
    do_data("ld_h2", 1'b0, 2'd1, 32'h0000_0026, 32'd0, 4'b0000, 32'd0, 1'b0);
    drive_idle();
    tick_neg();
    tick_pos();

    // Fetch cancelled in the response cycle.
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h0000_0004;
    tick_neg();
    check("cancel.inst_gnt", 32'(bus.inst_gnt), 32'd1);
    tick_pos();
    drive_idle();
    bus.inst_cancel = 1'b1;
    tick_neg();
    tick_pos();

    // Cancel during the request cycle does not block the grant or the response.
    bus.inst_req    = 1'b1;
    bus.inst_addr   = 32'h0000_000C;
    bus.inst_cancel = 1'b1;
    tick_neg();
    check("cancel_req.inst_gnt", 32'(bus.inst_gnt), 32'd1);
    exp_inst_q.push_back(ref_mem[3]);
    exp_inst_next = 1'b1;
    tick_pos();
    drive_idle();
    tick_neg();
    tick_pos();

    // Reset in the cycle after a load grant drops the response.
    do_data("ld_rst", 1'b0, 2'd2, 32'h0000_0010, 32'd0, 4'b0000, 32'd0, 1'b0);
    exp_data_now = 1'b0;
    void'(exp_data_q.pop_back());
    reset = 1'b1;
    drive_idle();
    tick_neg();
    check("rst_mid.data_rdata", bus.data_rdata, 32'd0);
    tick_pos();
    reset = 1'b0;
    tick_neg();
    tick_pos();

    check("sb_inst_left", 32'(exp_inst_q.size()), 32'd0);
    check("sb_data_left", 32'(exp_data_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
